pw_relu_maxpool: RTL and testbench

//  Reader side of the pointwise-conv output interface: consumes the 9-channel

---
 rtl/pw_relu_maxpool.sv | 169 ++++++++++++++++
 tb/tb_pw_relu_maxpool.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pw_relu_maxpool.sv
`default_nettype none
// ============================================================================
// Module   : pw_relu_maxpool
// Purpose  : 2x2/2 max pooling of 9-channel pointwise-conv beats, then optional
//            ReLU (macro PW_POOL_RELU_EN), arithmetic shift and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module pw_relu_maxpool #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0,
  parameter int IMG_W = 26,
  parameter int IMG_H = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [9*IN_W-1:0]  pw_in,
  output logic [9*OUT_W-1:0] pool_out,
  output logic               valid_out,
  output logic [7:0]         pool_col,
  output logic [7:0]         pool_row,
  output logic               frame_done
);

  localparam int NCH      = 9;
  localparam int LB_N     = IMG_W / 2;
  localparam int AW       = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam int LB_DEPTH = 1 << AW;
  localparam int CW       = $clog2(IMG_W + 1);
  localparam int RW       = $clog2(IMG_H + 1);

  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST_ODD = CW'(2 * (IMG_W / 2) - 1);
  localparam logic [RW-1:0] ROW_LAST_ODD = RW'(2 * (IMG_H / 2) - 1);

`ifdef PW_POOL_RELU_EN
  localparam logic signed [IN_W-1:0] SAT_HI = IN_W'((2 ** OUT_W) - 1);
  localparam logic signed [IN_W-1:0] SAT_LO = '0;
`else
  localparam logic signed [IN_W-1:0] SAT_HI = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_LO = IN_W'(-(2 ** (OUT_W - 1)));
`endif

  typedef enum logic [0:0] {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [9*OUT_W-1:0] pool_q, pool_d;
  logic [7:0]         pcol_q, pcol_d;
  logic [7:0]         prow_q, prow_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic [AW-1:0]      w_addr;
  logic               w_lb_we;
  logic               w_emit;
  logic [9*OUT_W-1:0] w_res;

  assign w_addr  = col_q[AW:1];
  assign w_lb_we = valid_in && !rst && col_q[0] && (state_q == ROW_EVEN);
  assign w_emit  = col_q[0] && (state_q == ROW_ODD);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [IN_W-1:0] w_px;
    logic signed [IN_W-1:0] hmax_q;
    logic signed [IN_W-1:0] w_hpair;
    logic signed [IN_W-1:0] w_lb;
    logic signed [IN_W-1:0] w_m;
    logic signed [IN_W-1:0] w_v;
    logic [OUT_W-1:0]       w_out;
    logic signed [IN_W-1:0] lb_q [LB_DEPTH];

    assign w_px    = pw_in[k*IN_W +: IN_W];
    assign w_hpair = (w_px > hmax_q) ? w_px : hmax_q;
    assign w_lb    = lb_q[w_addr];
    assign w_m     = (w_lb > w_hpair) ? w_lb : w_hpair;

    always_comb begin
      w_v = w_m;
`ifdef PW_POOL_RELU_EN
      if (w_m[IN_W-1]) w_v = '0;
`endif
      w_v = w_v >>> SHIFT;
      if (w_v > SAT_HI)      w_out = SAT_HI[OUT_W-1:0];
      else if (w_v < SAT_LO) w_out = SAT_LO[OUT_W-1:0];
      else                   w_out = w_v[OUT_W-1:0];
    end

    assign w_res[k*OUT_W +: OUT_W] = w_out;

    always_ff @(posedge clk) begin
      if (rst)           hmax_q <= '0;
      else if (valid_in) hmax_q <= col_q[0] ? w_hpair : w_px;
    end

    // Line buffer carries no reset: every entry is written on an even row before it is read.
    always_ff @(posedge clk) begin
      if (w_lb_we) lb_q[w_addr] <= w_hpair;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    pool_d  = pool_q;
    pcol_d  = pcol_q;
    prow_d  = prow_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (valid_in) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = ROW_EVEN;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
      if (w_emit) begin
        valid_d = 1'b1;
        pool_d  = w_res;
        pcol_d  = 8'(col_q >> 1);
        prow_d  = 8'(row_q >> 1);
        done_d  = (col_q == COL_LAST_ODD) && (row_q == ROW_LAST_ODD);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ROW_EVEN;
      col_q   <= '0;
      row_q   <= '0;
      pool_q  <= '0;
      pcol_q  <= '0;
      prow_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pool_q  <= pool_d;
      pcol_q  <= pcol_d;
      prow_q  <= prow_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign pool_out   = pool_q;
  assign valid_out  = valid_q;
  assign pool_col   = pcol_q;
  assign pool_row   = prow_q;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pw_relu_maxpool.sv
`default_nettype none
// ============================================================================
// Module   : tb_pw_relu_maxpool
// Purpose  : Scoreboard bench for pw_relu_maxpool on a 4x4 map, SHIFT 0 and 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pw_relu_maxpool;

  typedef struct packed {
    logic [71:0] d;
    logic [7:0]  c;
    logic [7:0]  r;
    logic        fd;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_in = 1'b0;
  logic [143:0] pw_in = '0;

  logic [71:0]  a_pool, b_pool;
  logic         a_valid, b_valid, a_done, b_done;
  logic [7:0]   a_col, a_row, b_col, b_row;

  int n_total = 0;
  int n_bad   = 0;
  int n_push  = 0;
  int n_frames = 0;
  int a_seen = 0, b_seen = 0, a_fd = 0, b_fd = 0;
  int brow = 0, bcol = 0;
  int img [4][4][9];
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  pw_relu_maxpool #(.IN_W(16), .OUT_W(8), .SHIFT(0), .IMG_W(4), .IMG_H(4)) u_dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pw_in(pw_in),
    .pool_out(a_pool), .valid_out(a_valid), .pool_col(a_col), .pool_row(a_row),
    .frame_done(a_done)
  );

  pw_relu_maxpool #(.IN_W(16), .OUT_W(8), .SHIFT(2), .IMG_W(4), .IMG_H(4)) u_shf (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pw_in(pw_in),
    .pool_out(b_pool), .valid_out(b_valid), .pool_col(b_col), .pool_row(b_row),
    .frame_done(b_done)
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] sat8(input int m, input int sh);
    int v;
    v = m;
`ifdef PW_POOL_RELU_EN
    if (v < 0) v = 0;
    v = v >>> sh;
    if (v > 255) v = 255;
`else
    v = v >>> sh;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`endif
    return 8'(v);
  endfunction

  function automatic int pat(input int mode, input int r, input int c, input int k);
    int idx;
    idx = r * 4 + c;
    case (mode)
      0: return idx;
      1: return -300;
      2: return (k - 4) * 250 + idx * (k + 1) * 3;
      3: begin
        if (k == 0) return (idx == 5) ? 1000 : (idx == 15) ? 2000 : idx * 10;
        return (k * 100 - idx * 37) * (((k % 2) == 1) ? 1 : -1);
      end
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic send_beat(input int mode, input int gap);
    logic [143:0] bus;
    exp_t ea, eb;
    int m;
    for (int k = 0; k < 9; k++) begin
      img[brow][bcol][k] = pat(mode, brow, bcol, k);
      bus[k*16 +: 16] = 16'(img[brow][bcol][k]);
    end
    if ((brow % 2 == 1) && (bcol % 2 == 1)) begin
      ea = '0;
      eb = '0;
      for (int k = 0; k < 9; k++) begin
        m = img[brow][bcol][k];
        if (img[brow][bcol-1][k] > m)   m = img[brow][bcol-1][k];
        if (img[brow-1][bcol][k] > m)   m = img[brow-1][bcol][k];
        if (img[brow-1][bcol-1][k] > m) m = img[brow-1][bcol-1][k];
        ea.d[k*8 +: 8] = sat8(m, 0);
        eb.d[k*8 +: 8] = sat8(m, 2);
      end
      ea.c  = 8'(bcol / 2);
      ea.r  = 8'(brow / 2);
      ea.fd = (brow == 3) && (bcol == 3);
      eb.c  = ea.c;
      eb.r  = ea.r;
      eb.fd = ea.fd;
      qa.push_back(ea);
      qb.push_back(eb);
      n_push++;
      if (ea.fd) n_frames++;
    end
    valid_in = 1'b1;
    pw_in    = bus;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    pw_in    = '0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    if (bcol == 3) begin
      bcol = 0;
      brow = (brow == 3) ? 0 : brow + 1;
    end else begin
      bcol++;
    end
  endtask

  task automatic send_frame(input int mode, input int maxgap);
    for (int n = 0; n < 16; n++)
      send_beat(mode, (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_pool"},  a_pool, 72'h0);
    chk({tag, "_valid"}, 72'(a_valid), 72'h0);
    chk({tag, "_col"},   72'(a_col), 72'h0);
    chk({tag, "_row"},   72'(a_row), 72'h0);
    chk({tag, "_done"},  72'(a_done), 72'h0);
    chk({tag, "_shf_pool"}, b_pool, 72'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_valid) begin
      a_seen++;
      if (a_done) a_fd++;
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 72'(a_valid), 72'h0);
      end else begin
        e = qa.pop_front();
        chk("a_pool", a_pool, e.d);
        chk("a_col",  72'(a_col), 72'(e.c));
        chk("a_row",  72'(a_row), 72'(e.r));
        chk("a_done", 72'(a_done), 72'(e.fd));
      end
    end else begin
      chk("a_done_idle", 72'(a_done), 72'h0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_valid) begin
      b_seen++;
      if (b_done) b_fd++;
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 72'(b_valid), 72'h0);
      end else begin
        e = qb.pop_front();
        chk("b_pool", b_pool, e.d);
        chk("b_col",  72'(b_col), 72'(e.c));
        chk("b_row",  72'(b_row), 72'(e.r));
        chk("b_done", 72'(b_done), 72'(e.fd));
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_check("rst0");

    send_frame(0, 0);
    send_frame(1, 0);
    send_frame(2, 0);
    send_frame(3, 0);
    send_frame(0, 5);

    // Abandon a frame part way; the beat presented alongside rst must be dropped.
    for (int n = 0; n < 6; n++) send_beat(4, 0);
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b1;
    valid_in = 1'b1;
    pw_in    = {9{16'h7FFF}};
    @(posedge clk);
    #1;
    rst      = 1'b0;
    valid_in = 1'b0;
    pw_in    = '0;
    brow = 0;
    bcol = 0;
    reset_check("rst1");
    send_frame(2, 0);

    send_frame(4, 0);
    send_frame(4, 0);

    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("a_queue_empty", 72'(qa.size()), 72'h0);
    chk("b_queue_empty", 72'(qb.size()), 72'h0);
    chk("a_valid_count", 72'(a_seen), 72'(n_push));
    chk("b_valid_count", 72'(b_seen), 72'(n_push));
    chk("a_frame_done_count", 72'(a_fd), 72'(n_frames));
    chk("b_frame_done_count", 72'(b_fd), 72'(n_frames));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
